// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the single-port word memory M: fetch (port 0)
// and load/store (port 1) share M, one access per cycle, load data returned one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic              last_gnt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              gnt0_p0;
  logic              gnt1_p0;
  logic              rvld0_p1;
  logic              rvld1_p1;
  logic [DATA_W-1:0] rdata0_p1;
  logic [DATA_W-1:0] rdata1_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == WAIT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Stage p0: combinational arbitration and issue to M; nothing is granted while in reset
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
        if (FIXED_PRIO != 0) begin
          if (wait_cnt == WAIT_MAX) gnt1_p0 = 1'b1;
          else                      gnt0_p0 = 1'b1;
        end else begin
          if (last_gnt) gnt0_p0 = 1'b1;
          else          gnt1_p0 = 1'b1;
        end
      end else begin
        gnt0_p0 = p0_req;
        gnt1_p0 = p1_req;
      end
    end
  end

  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (gnt0_p0) begin
      m_read  = !p0_write;
      m_write = p0_write;
      m_addr  = p0_addr;
      m_wdata = p0_wdata;
    end else if (gnt1_p0) begin
      m_read  = !p1_write;
      m_write = p1_write;
      m_addr  = p1_addr;
      m_wdata = p1_wdata;
    end
  end

  // Stage p1: arbitration state and registered load response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      wait_cnt  <= '0;
      rvld0_p1  <= 1'b0;
      rvld1_p1  <= 1'b0;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
    end else begin
      rvld0_p1 <= gnt0_p0 && !p0_write;
      rvld1_p1 <= gnt1_p0 && !p1_write;
      if (gnt0_p0 && !p0_write) rdata0_p1 <= m_rdata;
      if (gnt1_p0 && !p1_write) rdata1_p1 <= m_rdata;
      if (gnt0_p0 || gnt1_p0) last_gnt <= gnt1_p0;
      if (!p1_req)       wait_cnt <= '0;
      else if (gnt1_p0)  wait_cnt <= '0;
      else if (gnt0_p0)  wait_cnt <= sat_inc(wait_cnt);
    end
  end

  assign p0_gnt    = gnt0_p0;
  assign p1_gnt    = gnt1_p0;
  assign p0_rvalid = rvld0_p1;
  assign p1_rvalid = rvld1_p1;
  assign p0_rdata  = rdata0_p1;
  assign p1_rdata  = rdata1_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin arbiter with a behavioural word memory, and a
// fixed-priority arbiter (MAX_WAIT=4) with an address-derived read-data stub.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Round-robin instance
  logic        rst, p0_req, p0_write, p1_req, p1_write;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, m_read, m_write;
  logic [31:0] p0_rdata, p1_rdata, m_addr, m_wdata, m_rdata;

  // Fixed-priority instance
  logic        f_rst, f_p0_req, f_p0_write, f_p1_req, f_p1_write;
  logic [31:0] f_p0_addr, f_p0_wdata, f_p1_addr, f_p1_wdata;
  logic        f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid, f_m_read, f_m_write;
  logic [31:0] f_p0_rdata, f_p1_rdata, f_m_addr, f_m_wdata, f_m_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .MAX_WAIT(4)) u_rr (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .MAX_WAIT(4)) u_fp (
    .clk(clk), .rst(f_rst),
    .p0_req(f_p0_req), .p0_write(f_p0_write), .p0_addr(f_p0_addr), .p0_wdata(f_p0_wdata),
    .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
    .p1_req(f_p1_req), .p1_write(f_p1_write), .p1_addr(f_p1_addr), .p1_wdata(f_p1_wdata),
    .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
    .m_read(f_m_read), .m_write(f_m_write), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
    .m_rdata(f_m_rdata));

  // Word memory M: store commits on the granted posedge, read is combinational
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
  always @(posedge clk) if (m_write) mem[m_addr[7:2]] <= m_wdata;
  assign m_rdata   = mem[m_addr[7:2]];
  assign f_m_rdata = f_m_addr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b1; f_rst = 1'b1;
    p0_req = 1'b1; p0_write = 1'b0; p0_addr = 32'h10; p0_wdata = 32'h0;
    p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h20; p1_wdata = 32'h0;
    f_p0_req = 1'b0; f_p0_write = 1'b0; f_p0_addr = 32'h100; f_p0_wdata = 32'h0;
    f_p1_req = 1'b0; f_p1_write = 1'b0; f_p1_addr = 32'h200; f_p1_wdata = 32'h0;

    // 1) reset with both requesting
    #2;
    chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    @(negedge clk); #1;
    chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p1_rdata", p1_rdata, 32'h0);

    // 2) release: p0 wins first, then strict alternation with 1-cycle rvalid
    @(negedge clk); rst = 1'b0; #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("rr_p0_gnt", 32'(p0_gnt), 32'(k % 2 == 0));
      chk("rr_p1_gnt", 32'(p1_gnt), 32'(k % 2 == 1));
      chk("rr_m_addr", m_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      chk("rr_m_read", 32'(m_read), 32'd1);
      if (k > 0) begin
        chk("rr_p0_rvalid", 32'(p0_rvalid), 32'(k % 2 == 1));
        chk("rr_p1_rvalid", 32'(p1_rvalid), 32'(k % 2 == 0));
        if (k % 2 == 1) chk("rr_p0_rdata", p0_rdata, 32'h1004);
        else            chk("rr_p1_rdata", p1_rdata, 32'h1008);
      end
    end
    @(negedge clk); p0_req = 1'b0; p1_req = 1'b0; #1;
    chk("idle_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("idle_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("idle_m_read", 32'(m_read), 32'd0);
    chk("idle_m_addr", m_addr, 32'h0);
    chk("last_p1_rvalid", 32'(p1_rvalid), 32'd1);
    chk("last_p0_rvalid", 32'(p0_rvalid), 32'd0);
    @(negedge clk); #1;
    chk("pulse_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("hold_p1_rdata", p1_rdata, 32'h1008);

    // 3/6) p1 store, then p0 load of the same word next cycle
    @(negedge clk);
    p1_req = 1'b1; p1_write = 1'b1; p1_addr = 32'h40; p1_wdata = 32'hDEADBEEF; #1;
    chk("st_p1_gnt", 32'(p1_gnt), 32'd1);
    chk("st_m_write", 32'(m_write), 32'd1);
    chk("st_m_read", 32'(m_read), 32'd0);
    chk("st_m_addr", m_addr, 32'h40);
    chk("st_m_wdata", m_wdata, 32'hDEADBEEF);
    @(negedge clk);
    p1_req = 1'b0; p1_write = 1'b0;
    p0_req = 1'b1; p0_write = 1'b0; p0_addr = 32'h40; #1;
    chk("ld_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("ld_m_read", 32'(m_read), 32'd1);
    chk("st_no_p1_rvalid", 32'(p1_rvalid), 32'd0);
    @(negedge clk); p0_req = 1'b0; #1;
    chk("raw_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("raw_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("st_no_p1_rvalid2", 32'(p1_rvalid), 32'd0);

    // round-robin after p0 was last winner: p1 wins the contest
    @(negedge clk); p0_req = 1'b1; p1_req = 1'b1; p0_addr = 32'h10; #1;
    chk("rr2_p1_gnt", 32'(p1_gnt), 32'd1);
    chk("rr2_p0_gnt", 32'(p0_gnt), 32'd0);

    // 5) reset pulsed while a p0 load is in flight
    @(negedge clk); p1_req = 1'b0; #1;
    chk("kill_p0_gnt", 32'(p0_gnt), 32'd1);
    #2; rst = 1'b1; #1;
    chk("kill_gnt_in_rst", 32'(p0_gnt), 32'd0);
    @(posedge clk); #1;
    chk("kill_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("kill_p0_rdata", p0_rdata, 32'h0);
    chk("kill_p1_rdata", p1_rdata, 32'h0);
    @(negedge clk); rst = 1'b0; p0_req = 1'b0;
    @(negedge clk); #1;
    chk("kill_post_rvalid", 32'(p0_rvalid), 32'd0);
    chk("kill_post_rdata", p0_rdata, 32'h0);
    p0_req = 1'b1; p1_req = 1'b1; #1;
    chk("rst2_p0_first", 32'(p0_gnt), 32'd1);
    @(negedge clk); p0_req = 1'b0; p1_req = 1'b0;

    // 4) fixed priority with starvation guard
    @(negedge clk); f_rst = 1'b0; f_p0_req = 1'b1; f_p1_req = 1'b1; #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("fp_p1_gnt", 32'(f_p1_gnt), 32'(k % 5 == 4));
      chk("fp_p0_gnt", 32'(f_p0_gnt), 32'(k % 5 != 4));
      if (k % 5 == 0 && k > 0) begin
        chk("fp_p1_rvalid", 32'(f_p1_rvalid), 32'd1);
        chk("fp_p1_rdata", f_p1_rdata, 32'hA5A5_0200);
      end
    end
    // p1 dropping its request clears the wait count
    @(negedge clk); f_p1_req = 1'b0; #1;
    chk("fp_solo_p0_gnt", 32'(f_p0_gnt), 32'd1);
    @(negedge clk); f_p1_req = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("fp2_p1_gnt", 32'(f_p1_gnt), 32'(k == 4));
    end
    @(negedge clk); f_p0_req = 1'b0; f_p1_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
